// File: rtl/ps2_scan_receiver_if.sv
// PS/2 receive-side bundle: raw connector lines in, decoded scan-code events out.
// The slave modport is the receiver; the master side drives the lines and consumes events.
interface ps2_scan_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       code_valid;
    logic       frame_error;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output code,
        output extended,
        output released,
        output code_valid,
        output frame_error
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  code,
        input  extended,
        input  released,
        input  code_valid,
        input  frame_error
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and filters the lines, checks framing,
// folds 0xE0/0xF0 prefixes into flags and strobes one scan code per key event.
module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_scan_receiver_if.slave    bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0]     sync1_reg;
    logic [1:0]     sync2_reg;
    logic           clk_s;
    logic           data_s;

    logic           filt_reg;
    logic           filt_next;
    logic [FCW-1:0] filt_cnt_reg;
    logic [FCW-1:0] filt_cnt_next;
    logic           sample_pt;

    state_t         state_reg;
    state_t         state_next;
    logic [2:0]     bit_cnt_reg;
    logic [2:0]     bit_cnt_next;
    logic [7:0]     shift_reg;
    logic [7:0]     shift_next;
    logic           parity_reg;
    logic           parity_next;
    logic [TCW-1:0] timeout_reg;
    logic [TCW-1:0] timeout_next;
    logic           ext_pending_reg;
    logic           ext_pending_next;
    logic           brk_pending_reg;
    logic           brk_pending_next;

    logic [7:0]     code_reg;
    logic [7:0]     code_next;
    logic           extended_reg;
    logic           extended_next;
    logic           released_reg;
    logic           released_next;
    logic           code_valid_reg;
    logic           code_valid_next;
    logic           frame_error_reg;
    logic           frame_error_next;

    logic           parity_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 2'b11;
            sync2_reg <= 2'b11;
        end else begin
            sync1_reg <= {bus.ps2_data, bus.ps2_clk};
            sync2_reg <= sync1_reg;
        end
    end

    assign clk_s  = sync2_reg[0];
    assign data_s = sync2_reg[1];

    // Level flips on the FILTER_LEN-th consecutive differing sample; any agreeing sample restarts the run.
    always_comb begin
        filt_next     = filt_reg;
        filt_cnt_next = '0;
        if (clk_s != filt_reg) begin
            if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
                filt_next = clk_s;
            end else begin
                filt_cnt_next = filt_cnt_reg + 1'b1;
            end
        end
    end

    assign sample_pt = filt_reg & ~filt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_reg     <= 1'b1;
            filt_cnt_reg <= '0;
        end else begin
            filt_reg     <= filt_next;
            filt_cnt_reg <= filt_cnt_next;
        end
    end

    // Odd parity over data + parity bit.
    assign parity_ok = ^{shift_reg, parity_reg};

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        timeout_next     = timeout_reg;
        ext_pending_next = ext_pending_reg;
        brk_pending_next = brk_pending_reg;
        code_next        = code_reg;
        extended_next    = extended_reg;
        released_next    = released_reg;
        code_valid_next  = 1'b0;
        frame_error_next = 1'b0;

        if (sample_pt) begin
            timeout_next = '0;
            unique case (state_reg)
                IDLE: begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                DATA: begin
                    shift_next = {data_s, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
                PARITY: begin
                    parity_next = data_s;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (parity_ok && data_s) begin
                        if (shift_reg == 8'hE0) begin
                            ext_pending_next = 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            brk_pending_next = 1'b1;
                        end else begin
                            code_next        = shift_reg;
                            extended_next    = ext_pending_reg;
                            released_next    = brk_pending_reg;
                            code_valid_next  = 1'b1;
                            ext_pending_next = 1'b0;
                            brk_pending_next = 1'b0;
                        end
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE) begin
            if (timeout_reg == TCW'(TIMEOUT_CYCLES - 1)) begin
                frame_error_next = 1'b1;
                state_next       = IDLE;
                timeout_next     = '0;
            end else begin
                timeout_next = timeout_reg + 1'b1;
            end
        end

        // A bad or aborted frame may have swallowed the byte a prefix was waiting for.
        if (frame_error_next) begin
            ext_pending_next = 1'b0;
            brk_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            timeout_reg     <= '0;
            ext_pending_reg <= 1'b0;
            brk_pending_reg <= 1'b0;
            code_reg        <= '0;
            extended_reg    <= 1'b0;
            released_reg    <= 1'b0;
            code_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            timeout_reg     <= timeout_next;
            ext_pending_reg <= ext_pending_next;
            brk_pending_reg <= brk_pending_next;
            code_reg        <= code_next;
            extended_reg    <= extended_next;
            released_reg    <= released_next;
            code_valid_reg  <= code_valid_next;
            frame_error_reg <= frame_error_next;
        end
    end

    assign bus.code        = code_reg;
    assign bus.extended    = extended_reg;
    assign bus.released    = released_reg;
    assign bus.code_valid  = code_valid_reg;
    assign bus.frame_error = frame_error_reg;
endmodule
